// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide instruction buffer between the registered IF/ID packet
// and decode. Compacts partially valid fetch pairs into single slots, absorbs
// decode back-pressure, presents the two oldest entries and drives the stall
// vector back to fetch. Flushed by back-end branch recovery.
//
// Optional feature macro: FQ_BYPASS_EN
//   defined   - on an empty queue, accepted enqueue entries drive the outputs
//               in the same cycle; entries taken by decode are never written.
//   undefined - no bypass; out_valid depends only on the registered count.

`ifndef ALEN
`define ALEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module fetch_queue #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [1:0]                  enq_valid,
    input  logic [1:0][`ALEN-1:0]       enq_pc,
    input  logic [1:0][`XLEN-1:0]       enq_inst,
    input  logic [1:0]                  enq_bp_hit,
    input  logic [1:0][1:0]             enq_bp_state,
    input  logic [1:0]                  deq_ready,
    output logic [1:0]                  out_valid,
    output logic [1:0][`ALEN-1:0]       out_pc,
    output logic [1:0][`XLEN-1:0]       out_inst,
    output logic [1:0]                  out_bp_hit,
    output logic [1:0][1:0]             out_bp_state,
    output logic [1:0]                  fq_stall,
    output logic [PTR_W:0]              count,
    output logic                        overflow
);

    // Slot storage (contents are don't-care out of reset, so never reset)
    logic [`ALEN-1:0]   pc_mem_q    [DEPTH];
    logic [`XLEN-1:0]   inst_mem_q  [DEPTH];
    logic               hit_mem_q   [DEPTH];
    logic [1:0]         state_mem_q [DEPTH];

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q,  count_d;
    logic               overflow_q, overflow_d;
    logic [1:0]         fq_stall_q, fq_stall_d;

    // Compacted enqueue lanes: lane 0 is the oldest valid fetch slot
    logic [1:0][`ALEN-1:0] c_pc_s;
    logic [1:0][`XLEN-1:0] c_inst_s;
    logic [1:0]            c_hit_s;
    logic [1:0][1:0]       c_state_s;
    logic [1:0]            n_enq_s;
    logic [1:0]            n_deq_s;
    logic                  kill_s;
    logic                  byp_s;
    logic                  accept_s;
    logic [1:0]            we_s;
    logic [PTR_W-1:0]      rd1_s;
    logic [PTR_W-1:0]      wa1_s;
    logic [PTR_W+1:0]      space_s;

    // Compact the fetch pair so valid entries occupy consecutive lanes
    always_comb begin
        n_enq_s = {1'b0, enq_valid[0]} + {1'b0, enq_valid[1]};
        if (enq_valid[0]) begin
            c_pc_s    = enq_pc;
            c_inst_s  = enq_inst;
            c_hit_s   = enq_bp_hit;
            c_state_s = enq_bp_state;
        end else begin
            c_pc_s    = {enq_pc[1],       enq_pc[1]};
            c_inst_s  = {enq_inst[1],     enq_inst[1]};
            c_hit_s   = {enq_bp_hit[1],   enq_bp_hit[1]};
            c_state_s = {enq_bp_state[1], enq_bp_state[1]};
        end
    end

    // Head read, optional empty-queue bypass and dequeue count
    always_comb begin
        kill_s       = rst | flush;
        rd1_s        = rd_ptr_q + PTR_W'(1);
        byp_s        = 1'b0;
        out_pc       = {pc_mem_q[rd1_s],    pc_mem_q[rd_ptr_q]};
        out_inst     = {inst_mem_q[rd1_s],  inst_mem_q[rd_ptr_q]};
        out_bp_hit   = {hit_mem_q[rd1_s],   hit_mem_q[rd_ptr_q]};
        out_bp_state = {state_mem_q[rd1_s], state_mem_q[rd_ptr_q]};
        out_valid    = {(count_q >= (PTR_W+1)'(2)) & ~kill_s,
                        (count_q >= (PTR_W+1)'(1)) & ~kill_s};
`ifdef FQ_BYPASS_EN
        if ((count_q == (PTR_W+1)'(0)) && !kill_s) begin
            byp_s        = 1'b1;
            out_pc       = c_pc_s;
            out_inst     = c_inst_s;
            out_bp_hit   = c_hit_s;
            out_bp_state = c_state_s;
            out_valid    = {n_enq_s == 2'd2, n_enq_s != 2'd0};
        end else begin
            byp_s        = 1'b0;
        end
`endif
        n_deq_s = {1'b0, out_valid[0] & deq_ready[0]}
                + {1'b0, out_valid[1] & deq_ready[1] & deq_ready[0]};
    end

    // Space check against this cycle's dequeue, and per-lane write enables
    always_comb begin
        space_s  = (PTR_W+2)'(DEPTH) - (PTR_W+2)'(count_q) + (PTR_W+2)'(n_deq_s);
        accept_s = ((PTR_W+2)'(n_enq_s) <= space_s);
        wa1_s    = wr_ptr_q + PTR_W'(1);
        // Bypassed entries already taken by decode are not stored
        we_s[0]  = ~kill_s & accept_s & (n_enq_s != 2'd0) & ~(byp_s & (n_deq_s != 2'd0));
        we_s[1]  = ~kill_s & accept_s & (n_enq_s == 2'd2) & ~(byp_s & (n_deq_s == 2'd2));
    end

    // Next-state pointers, occupancy, sticky overflow and stall
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
            count_d  = (PTR_W+1)'(0);
        end else if (accept_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(n_deq_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(n_enq_s);
            count_d  = count_q + (PTR_W+1)'(n_enq_s) - (PTR_W+1)'(n_deq_s);
        end else begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(n_deq_s);
            count_d    = count_q - (PTR_W+1)'(n_deq_s);
            overflow_d = 1'b1;
        end
        fq_stall_d = {2{count_d > (PTR_W+1)'(DEPTH - 4)}};
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= PTR_W'(0);
            wr_ptr_q   <= PTR_W'(0);
            count_q    <= (PTR_W+1)'(0);
            overflow_q <= 1'b0;
            fq_stall_q <= 2'b00;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            fq_stall_q <= fq_stall_d;
        end
    end

    // Slot writes: compacted lanes go to wr_ptr and wr_ptr+1
    always_ff @(posedge clk) begin
        if (we_s[0]) begin
            pc_mem_q[wr_ptr_q]    <= c_pc_s[0];
            inst_mem_q[wr_ptr_q]  <= c_inst_s[0];
            hit_mem_q[wr_ptr_q]   <= c_hit_s[0];
            state_mem_q[wr_ptr_q] <= c_state_s[0];
        end
        if (we_s[1]) begin
            pc_mem_q[wa1_s]    <= c_pc_s[1];
            inst_mem_q[wa1_s]  <= c_inst_s[1];
            hit_mem_q[wa1_s]   <= c_hit_s[1];
            state_mem_q[wa1_s] <= c_state_s[1];
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign fq_stall = fq_stall_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=8): a table of per-cycle vectors
// with hand-derived expectations, plus a scoreboard queue of expected entries
// pushed on accepted enqueue and popped when decode takes them.

`ifndef ALEN
`define ALEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam logic [31:0] INST_TAG = 32'hA5C3_0000;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [1:0]            enq_valid;
    logic [1:0][`ALEN-1:0] enq_pc;
    logic [1:0][`XLEN-1:0] enq_inst;
    logic [1:0]            enq_bp_hit;
    logic [1:0][1:0]       enq_bp_state;
    logic [1:0]            deq_ready;
    logic [1:0]            out_valid;
    logic [1:0][`ALEN-1:0] out_pc;
    logic [1:0][`XLEN-1:0] out_inst;
    logic [1:0]            out_bp_hit;
    logic [1:0][1:0]       out_bp_state;
    logic [1:0]            fq_stall;
    logic [3:0]            count;
    logic                  overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic        ovf_m = 1'b0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
        .enq_bp_hit(enq_bp_hit), .enq_bp_state(enq_bp_state),
        .deq_ready(deq_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_bp_hit(out_bp_hit), .out_bp_state(out_bp_state),
        .fq_stall(fq_stall), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [66:0] entry_of(input logic [31:0] pc);
        return {pc, INST_TAG ^ pc, pc[2], pc[4:3]};
    endfunction

    // One clock of stimulus; scoreboard checks heads before the edge and
    // occupancy/stall/overflow after it.
    task automatic step(input logic r, input logic fl, input logic [1:0] ev,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] dr);
        logic [31:0] c0, c1;
        int n_enq, n_deq;
        logic kill, byp, mv0, mv1;
        @(negedge clk);
        rst          = r;
        flush        = fl;
        enq_valid    = ev;
        enq_pc       = {p1, p0};
        enq_inst     = {INST_TAG ^ p1, INST_TAG ^ p0};
        enq_bp_hit   = {p1[2], p0[2]};
        enq_bp_state = {p1[4:3], p0[4:3]};
        deq_ready    = dr;
        #1;
        n_enq = int'(ev[0]) + int'(ev[1]);
        c0 = ev[0] ? p0 : p1;
        c1 = p1;
        kill = r | fl;
        byp  = 1'b0;
`ifdef FQ_BYPASS_EN
        if (!kill && sb.size() == 0) begin
            byp = 1'b1;
            if (n_enq >= 1) sb.push_back(c0);
            if (n_enq == 2) sb.push_back(c1);
        end
`endif
        mv0 = !kill && sb.size() >= 1;
        mv1 = !kill && sb.size() >= 2;
        chk("out_valid", {94'd0, out_valid}, {94'd0, mv1, mv0});
        if (mv0) chk("head0", {29'd0, out_pc[0], out_inst[0], out_bp_hit[0], out_bp_state[0]},
                     {29'd0, entry_of(sb[0])});
        if (mv1) chk("head1", {29'd0, out_pc[1], out_inst[1], out_bp_hit[1], out_bp_state[1]},
                     {29'd0, entry_of(sb[1])});
        n_deq = int'(mv0 & dr[0]) + int'(mv1 & dr[1] & dr[0]);
        for (int k = 0; k < n_deq; k++) void'(sb.pop_front());
        if (kill) begin
            sb.delete();
            if (r) ovf_m = 1'b0;
        end else if (!byp) begin
            if (n_enq + sb.size() <= DEPTH) begin
                if (n_enq >= 1) sb.push_back(c0);
                if (n_enq == 2) sb.push_back(c1);
            end else begin
                ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("count", {92'd0, count}, 96'(sb.size()));
        chk("fq_stall", {94'd0, fq_stall}, {94'd0, {2{sb.size() > DEPTH - 4}}});
        chk("overflow", {95'd0, overflow}, {95'd0, ovf_m});
    endtask

    typedef struct {
        logic        r;
        logic        fl;
        logic [1:0]  ev;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  dr;
        logic [3:0]  cnt;
        logic [1:0]  ov;
        logic        chk_pc;
        logic [31:0] hpc;
        logic [1:0]  st;
        logic        ovf;
    } vec_t;

    vec_t tbl[27];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2'b11, 32'h00, 32'h02, 2'b00, 4'd2, 2'b11, 1'b1, 32'h00, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'b11, 32'h04, 32'h06, 2'b00, 4'd4, 2'b11, 1'b1, 32'h00, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'b11, 32'h08, 32'h0A, 2'b00, 4'd6, 2'b11, 1'b1, 32'h00, 2'b11, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 4'd5, 2'b11, 1'b1, 32'h02, 2'b11, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 4'd3, 2'b11, 1'b1, 32'h06, 2'b00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 4'd2, 2'b11, 1'b1, 32'h08, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 4'd1, 2'b01, 1'b1, 32'h0A, 2'b00, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 4'd0, 2'b00, 1'b0, 32'h00, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'b10, 32'hFF, 32'h12, 2'b00, 4'd1, 2'b01, 1'b1, 32'h12, 2'b00, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 4'd0, 2'b00, 1'b0, 32'h00, 2'b00, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'b11, 32'h20, 32'h22, 2'b00, 4'd2, 2'b11, 1'b1, 32'h20, 2'b00, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'b11, 32'h24, 32'h26, 2'b00, 4'd4, 2'b11, 1'b1, 32'h20, 2'b00, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'b11, 32'h28, 32'h2A, 2'b00, 4'd6, 2'b11, 1'b1, 32'h20, 2'b11, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 2'b11, 32'h2C, 32'h2E, 2'b00, 4'd8, 2'b11, 1'b1, 32'h20, 2'b11, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'b11, 32'h30, 32'h32, 2'b11, 4'd8, 2'b11, 1'b1, 32'h24, 2'b11, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 2'b11, 32'h34, 32'h36, 2'b11, 4'd8, 2'b11, 1'b1, 32'h28, 2'b11, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'b11, 32'h38, 32'h3A, 2'b11, 4'd8, 2'b11, 1'b1, 32'h2C, 2'b11, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 2'b11, 32'h3C, 32'h3E, 2'b11, 4'd8, 2'b11, 1'b1, 32'h30, 2'b11, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 2'b11, 32'h40, 32'h42, 2'b00, 4'd8, 2'b11, 1'b1, 32'h30, 2'b11, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 4'd7, 2'b11, 1'b1, 32'h32, 2'b11, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 2'b11, 32'h44, 32'h46, 2'b00, 4'd7, 2'b11, 1'b1, 32'h32, 2'b11, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 2'b11, 32'h48, 32'h4A, 2'b00, 4'd0, 2'b00, 1'b0, 32'h00, 2'b00, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 4'd0, 2'b00, 1'b0, 32'h00, 2'b00, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 2'b01, 32'h50, 32'h52, 2'b00, 4'd1, 2'b01, 1'b1, 32'h50, 2'b00, 1'b1};
        tbl[24] = '{1'b1, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 4'd0, 2'b00, 1'b0, 32'h00, 2'b00, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 2'b11, 32'h60, 32'h62, 2'b00, 4'd2, 2'b11, 1'b1, 32'h60, 2'b00, 1'b0};
        tbl[26] = '{1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 4'd0, 2'b00, 1'b0, 32'h00, 2'b00, 1'b0};

        rst          = 1'b1;
        flush        = 1'b0;
        enq_valid    = 2'b00;
        enq_pc       = '0;
        enq_inst     = '0;
        enq_bp_hit   = 2'b00;
        enq_bp_state = '0;
        deq_ready    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", {92'd0, count}, 96'd0);
        chk("reset_out_valid", {94'd0, out_valid}, 96'd0);
        chk("reset_stall", {94'd0, fq_stall}, 96'd0);
        chk("reset_overflow", {95'd0, overflow}, 96'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].r, tbl[i].fl, tbl[i].ev, tbl[i].p0, tbl[i].p1, tbl[i].dr);
`ifndef FQ_BYPASS_EN
            chk($sformatf("vec%0d_count", i), {92'd0, count}, {92'd0, tbl[i].cnt});
            chk($sformatf("vec%0d_out_valid", i), {94'd0, out_valid}, {94'd0, tbl[i].ov});
            if (tbl[i].chk_pc)
                chk($sformatf("vec%0d_head_pc", i), {64'd0, out_pc[0]}, {64'd0, tbl[i].hpc});
            chk($sformatf("vec%0d_stall", i), {94'd0, fq_stall}, {94'd0, tbl[i].st});
            chk($sformatf("vec%0d_overflow", i), {95'd0, overflow}, {95'd0, tbl[i].ovf});
`endif
        end

        // Flush from a partly filled queue while fetch offers a pair
        step(1'b0, 1'b0, 2'b11, 32'h80, 32'h82, 2'b00);
        step(1'b0, 1'b0, 2'b11, 32'h84, 32'h86, 2'b00);
        step(1'b0, 1'b1, 2'b11, 32'h88, 32'h8A, 2'b11);
        step(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00);
        chk("post_flush_count", {92'd0, count}, 96'd0);
        chk("post_flush_out_valid", {94'd0, out_valid}, 96'd0);

        // Decode accepting only lane 1 (non-thermometer) takes nothing
        step(1'b0, 1'b0, 2'b11, 32'h90, 32'h92, 2'b00);
        step(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b10);
        step(1'b0, 1'b0, 2'b01, 32'h94, 32'h00, 2'b01);
        step(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11);
        step(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11);

`ifdef FQ_BYPASS_EN
        // Empty-queue bypass: pair taken in the same cycle, nothing stored
        step(1'b0, 1'b0, 2'b11, 32'hA0, 32'hA2, 2'b11);
        chk("bypass_count", {92'd0, count}, 96'd0);
        step(1'b0, 1'b0, 2'b11, 32'hA4, 32'hA6, 2'b01);
        chk("bypass_partial_count", {92'd0, count}, 96'd1);
        step(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
